g_m_rb_interp: RTL and testbench

G_M_RB_INTERP -- requirements
Module: g_m_rb_interp

---
 rtl/g_m_rb_interp_pkg.sv | 23 ++
 rtl/g_m_rb_interp_cdiff.sv | 20 ++
 rtl/g_m_rb_interp.sv | 111 +++++++++++
 tb/tb_g_m_rb_interp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/g_m_rb_interp_pkg.sv
// Shared CFA constants: pixel width, colour-difference width and clip limits.
// Helper functions let parameterised consumers derive the same values.
package g_m_rb_interp_pkg;

   localparam int CFA_PIX_W = 12;

   function automatic int cfa_diff_w(input int pix_w);
      return pix_w - 32'sd2;
   endfunction

   function automatic int cfa_clip_hi(input int pix_w);
      return (32'sd1 <<< (pix_w - 32'sd3)) - 32'sd1;
   endfunction

   function automatic int cfa_clip_lo(input int pix_w);
      return -(32'sd1 <<< (pix_w - 32'sd3));
   endfunction

   localparam int CFA_DIFF_W   = cfa_diff_w(CFA_PIX_W);
   localparam int CFA_DIFF_MAX = cfa_clip_hi(CFA_PIX_W);
   localparam int CFA_DIFF_MIN = cfa_clip_lo(CFA_PIX_W);

endpackage

// File: rtl/g_m_rb_interp_cdiff.sv
// One neighbour colour difference d = g_n - rb_n, both zero-extended,
// formed as a two's-complement add of the inverted subtrahend.
module g_m_rb_interp_cdiff
   import g_m_rb_interp_pkg::*;
#(
   parameter int PixelBitWidth = CFA_PIX_W
) (
   input  logic [PixelBitWidth-1:0]        g_n,
   input  logic [PixelBitWidth-1:0]        rb_n,
   output logic signed [PixelBitWidth:0]   d
);

   logic [PixelBitWidth:0] g_ext_s;
   logic [PixelBitWidth:0] rb_inv_s;

   assign g_ext_s  = {1'b0, g_n};
   assign rb_inv_s = ~{1'b0, rb_n};
   assign d        = signed'(g_ext_s + rb_inv_s + {{PixelBitWidth{1'b0}}, 1'b1});

endmodule

// File: rtl/g_m_rb_interp.sv
// Three-stage pipeline averaging four G-RB neighbour differences with
// round-half-up and symmetric clipping; whole-pipe stall on backpressure.
module g_m_rb_interp
   import g_m_rb_interp_pkg::*;
#(
   parameter int PixelBitWidth = CFA_PIX_W
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [PixelBitWidth-1:0]                   g,
   input  logic [PixelBitWidth-1:0]                   g_n0,
   input  logic [PixelBitWidth-1:0]                   g_n1,
   input  logic [PixelBitWidth-1:0]                   g_n2,
   input  logic [PixelBitWidth-1:0]                   g_n3,
   input  logic [PixelBitWidth-1:0]                   rb_n0,
   input  logic [PixelBitWidth-1:0]                   rb_n1,
   input  logic [PixelBitWidth-1:0]                   rb_n2,
   input  logic [PixelBitWidth-1:0]                   rb_n3,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [PixelBitWidth-1:0]                   g_out,
   output logic [cfa_diff_w(PixelBitWidth)-1:0]       g_m_rb,
   output logic                                       sat_flag
);

   localparam int DW = cfa_diff_w(PixelBitWidth);
   localparam int SW = PixelBitWidth + 3;
   localparam logic signed [SW-1:0] CLIP_HI = SW'(cfa_clip_hi(PixelBitWidth));
   localparam logic signed [SW-1:0] CLIP_LO = SW'(cfa_clip_lo(PixelBitWidth));
   localparam logic signed [SW-1:0] ROUND   = SW'(32'sd2);

   logic                               adv_s;
   logic [PixelBitWidth-1:0]           g_n_s  [4];
   logic [PixelBitWidth-1:0]           rb_n_s [4];
   logic signed [PixelBitWidth:0]      d_s    [4];
   logic signed [PixelBitWidth:0]      d_r    [4];
   logic                               v1_r, v2_r;
   logic [PixelBitWidth-1:0]           g1_r, g2_r;
   logic signed [PixelBitWidth+1:0]    p0_s, p1_s, p0_r, p1_r;
   logic signed [SW-1:0]               s_s, avg_s;
   logic [DW-1:0]                      clip_s;
   logic                               sat_s;

   assign adv_s    = out_ready || !out_valid;
   assign in_ready = adv_s;

   assign g_n_s  = '{g_n0, g_n1, g_n2, g_n3};
   assign rb_n_s = '{rb_n0, rb_n1, rb_n2, rb_n3};

   for (genvar i = 0; i < 4; i++) begin : g_cdiff
      g_m_rb_interp_cdiff #(.PixelBitWidth(PixelBitWidth)) u_cdiff (
         .g_n  (g_n_s[i]),
         .rb_n (rb_n_s[i]),
         .d    (d_s[i])
      );
   end

   // Pair sums are sign-extended by one bit so they cannot overflow.
   assign p0_s  = {d_r[0][PixelBitWidth], d_r[0]} + {d_r[1][PixelBitWidth], d_r[1]};
   assign p1_s  = {d_r[2][PixelBitWidth], d_r[2]} + {d_r[3][PixelBitWidth], d_r[3]};
   assign s_s   = {p0_r[PixelBitWidth+1], p0_r} + {p1_r[PixelBitWidth+1], p1_r};
   assign avg_s = (s_s + ROUND) >>> 2'd2;

   // Clip the rounded average into the signed colour-difference range.
   always_comb begin
      clip_s = avg_s[DW-1:0];
      sat_s  = 1'b0;
      if (avg_s > CLIP_HI) begin
         clip_s = CLIP_HI[DW-1:0];
         sat_s  = 1'b1;
      end else if (avg_s < CLIP_LO) begin
         clip_s = CLIP_LO[DW-1:0];
         sat_s  = 1'b1;
      end else begin
         clip_s = avg_s[DW-1:0];
         sat_s  = 1'b0;
      end
   end

   // Stage registers; reset wins over advance, and everything holds on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r      <= 1'b0;
         v2_r      <= 1'b0;
         out_valid <= 1'b0;
         g1_r      <= '0;
         g2_r      <= '0;
         d_r       <= '{default: '0};
         p0_r      <= '0;
         p1_r      <= '0;
         g_out     <= '0;
         g_m_rb    <= '0;
         sat_flag  <= 1'b0;
      end else if (adv_s) begin
         v1_r      <= in_valid;
         g1_r      <= g;
         d_r       <= d_s;
         v2_r      <= v1_r;
         g2_r      <= g1_r;
         p0_r      <= p0_s;
         p1_r      <= p1_s;
         out_valid <= v2_r;
         g_out     <= g2_r;
         g_m_rb    <= clip_s;
         sat_flag  <= sat_s;
      end
   end

endmodule

// File: tb/tb_g_m_rb_interp.sv
// Scoreboard bench for g_m_rb_interp: directed spec vectors, backpressure,
// mid-stream reset and a randomised stream against an arithmetic model.
module tb_g_m_rb_interp;

   localparam int PW      = 12;
   localparam int DW      = 10;
   localparam int CLIP_HI = 511;
   localparam int CLIP_LO = -512;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, sat_flag;
   logic [PW-1:0] g, g_n0, g_n1, g_n2, g_n3, rb_n0, rb_n1, rb_n2, rb_n3, g_out;
   logic [DW-1:0] g_m_rb;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;

   typedef struct {
      logic [PW-1:0] g;
      logic [DW-1:0] d;
      logic          sat;
   } exp_t;

   exp_t sb[$];

   g_m_rb_interp #(.PixelBitWidth(PW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .g(g), .g_n0(g_n0), .g_n1(g_n1), .g_n2(g_n2), .g_n3(g_n3),
      .rb_n0(rb_n0), .rb_n1(rb_n1), .rb_n2(rb_n2), .rb_n3(rb_n3),
      .out_valid(out_valid), .out_ready(out_ready),
      .g_out(g_out), .g_m_rb(g_m_rb), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Average of four differences, rounded half toward +inf, then clipped.
   function automatic exp_t model(input int gc, input int s);
      exp_t e;
      int num, q;
      num = s + 2;
      q = num / 4;
      if ((num % 4 != 0) && (num < 0)) q = q - 1;
      e.sat = 1'b0;
      if (q > CLIP_HI) begin
         q = CLIP_HI; e.sat = 1'b1;
      end else if (q < CLIP_LO) begin
         q = CLIP_LO; e.sat = 1'b1;
      end
      e.g = PW'(gc);
      e.d = DW'(q);
      return e;
   endfunction

   // Stimulus recorder: an input transfer happens at the coming edge.
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready) begin
         sb.push_back(model(int'(g),
            (int'(g_n0) - int'(rb_n0)) + (int'(g_n1) - int'(rb_n1)) +
            (int'(g_n2) - int'(rb_n2)) + (int'(g_n3) - int'(rb_n3))));
      end
   end

   // Output monitor: pop and compare on every output transfer.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = sb.pop_front();
            check("g_out", int'(g_out), int'(e.g));
            check("g_m_rb", int'(g_m_rb), int'(e.d));
            check("sat_flag", int'(sat_flag), int'(e.sat));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input int gc, input int gn[4], input int rbn[4]);
      bit ok;
      ok = 1'b0;
      g = PW'(gc);
      g_n0 = PW'(gn[0]); g_n1 = PW'(gn[1]); g_n2 = PW'(gn[2]); g_n3 = PW'(gn[3]);
      rb_n0 = PW'(rbn[0]); rb_n1 = PW'(rbn[1]); rb_n2 = PW'(rbn[2]); rb_n3 = PW'(rbn[3]);
      in_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gn[4], rbn[4];
      int lat;
      time t0;
      logic [PW-1:0] snap_g;
      logic [DW-1:0] snap_d;
      logic          snap_s;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      g = '0; g_n0 = '0; g_n1 = '0; g_n2 = '0; g_n3 = '0;
      rb_n0 = '0; rb_n1 = '0; rb_n2 = '0; rb_n3 = '0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_g_m_rb", int'(g_m_rb), 0);
      check("rst_sat_flag", int'(sat_flag), 0);
      check("rst_g_out", int'(g_out), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // Latency from an empty pipe, with the flat-field vector.
      out_ready = 1'b1;
      gn = '{1000, 1000, 1000, 1000}; rbn = '{1000, 1000, 1000, 1000};
      send(2000, gn, rbn);
      in_valid = 1'b0;
      lat = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      check("latency", lat, 3);
      @(posedge clk); #1;
      idle(4);

      // Directed difference / rounding / saturation vectors, back to back.
      gn = '{110, 220, 330, 440}; rbn = '{100, 200, 300, 400}; send(123, gn, rbn);
      gn = '{0, 0, 0, 0};         rbn = '{1, 1, 1, 2};         send(77, gn, rbn);
      gn = '{5, 5, 7, 7};         rbn = '{6, 6, 7, 7};         send(4095, gn, rbn);
      gn = '{4095, 4095, 4095, 4095}; rbn = '{0, 0, 0, 0};     send(1, gn, rbn);
      gn = '{0, 0, 0, 0}; rbn = '{4095, 4095, 4095, 4095};     send(0, gn, rbn);
      idle(6);

      // Throughput: eight sets in eight cycles with out_ready high.
      t0 = $time;
      for (int k = 0; k < 8; k++) begin
         gn = '{k * 37, k * 11, 4095 - k, k}; rbn = '{k, 2 * k, k * 5, 3000};
         send(k * 100, gn, rbn);
      end
      check("throughput_cycles", int'(($time - t0) / 10), 8);
      idle(6);

      // Backpressure: hold out_ready low four cycles with the pipe full.
      fork
         begin
            int a[4], b[4];
            for (int k = 0; k < 8; k++) begin
               a = '{200 + k, 10 * k, 4000, k}; b = '{k, 0, 3990 - k, 50};
               send(500 + k, a, b);
            end
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               if (i == 0) begin
                  snap_g = g_out; snap_d = g_m_rb; snap_s = sat_flag;
               end else begin
                  check("stall_g_out", int'(g_out), int'(snap_g));
                  check("stall_g_m_rb", int'(g_m_rb), int'(snap_d));
                  check("stall_sat", int'(sat_flag), int'(snap_s));
               end
               check("stall_in_ready", int'(in_ready), 0);
               check("stall_out_valid", int'(out_valid), 1);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      idle(8);

      // Mid-stream reset with three sets in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         gn = '{3000, 3000, 3000, 3000}; rbn = '{k, k, k, k};
         send(900 + k, gn, rbn);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_g_m_rb", int'(g_m_rb), 0);
      check("midrst_sat", int'(sat_flag), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      idle(6);

      // Randomised stream with random gaps and random backpressure.
      rdy_mode = 1;
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 7))
            0: begin gn = '{4095, 4095, 4095, 4095}; rbn = '{0, 0, 0, 0}; end
            1: begin gn = '{0, 0, 0, 0}; rbn = '{4095, 4095, 4095, 4095}; end
            default: begin
               for (int i = 0; i < 4; i++) begin
                  gn[i]  = $urandom_range(0, 4095);
                  rbn[i] = $urandom_range(0, 4095);
               end
            end
         endcase
         send($urandom_range(0, 4095), gn, rbn);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int t = 0; t < 50; t++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
